// File: rtl/spike_rate_decoder.sv
// Rate decoder for a binary spike train: a halving synaptic current trace plus
// a windowed spike count delivered over a valid/ready handshake.
module spike_rate_decoder #(
   parameter int WINDOW = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spike,
   input  logic       enable,
   input  logic [7:0] weight,
   output logic [7:0] current,
   output logic [7:0] rate,
   output logic       rate_valid,
   input  logic       rate_ready,
   output logic       overrun
);

   localparam int              SLOT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WINDOW - 1);

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   state_t            state, state_next;
   logic [SLOT_W-1:0] slot, slot_next, slot_cur;
   logic [7:0]        count, count_next, count_cur, count_inc;
   logic              window_done;
   logic [8:0]        trace_sum;
   logic [7:0]        trace_next;

   // Leaky trace: halve, add the weight on a spike, clamp to 8 bits.
   always_comb begin
      trace_sum  = {2'b00, current[7:1]} + {1'b0, (spike ? weight : 8'd0)};
      trace_next = trace_sum[8] ? 8'hFF : trace_sum[7:0];
   end

   // The edge that leaves IDLE is slot 0 of a fresh window.
   always_comb begin
      slot_cur  = (state == IDLE) ? '0 : slot;
      count_cur = (state == IDLE) ? 8'd0 : count;
      count_inc = (spike && count_cur != 8'hFF) ? count_cur + 8'd1 : count_cur;
   end

   // NOTE: every output of this block is defaulted first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next  = state;
      slot_next   = slot;
      count_next  = count;
      window_done = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = COUNT;
               slot_next  = slot_cur + SLOT_W'(1);
               count_next = count_inc;
            end
         end
         COUNT: begin
            if (!enable) begin
               state_next = IDLE;
               slot_next  = '0;
               count_next = 8'd0;
            end else if (slot_cur == LAST_SLOT) begin
               window_done = 1'b1;
               slot_next   = '0;
               count_next  = 8'd0;
            end else begin
               slot_next  = slot_cur + SLOT_W'(1);
               count_next = count_inc;
            end
         end
         default: begin
            state_next = IDLE;
            slot_next  = '0;
            count_next = 8'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         slot  <= '0;
         count <= 8'd0;
      end else begin
         state <= state_next;
         slot  <= slot_next;
         count <= count_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         current    <= 8'd0;
         rate       <= 8'd0;
         rate_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (enable) begin
            current <= trace_next;
         end
         // A completing window wins over consumption; only an unread sample
         // that gets replaced counts as an overrun.
         if (window_done) begin
            rate       <= count_inc;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) begin
               overrun <= 1'b1;
            end
         end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_spike_rate_decoder;

   localparam int WINDOW = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       spike;
   logic       enable;
   logic [7:0] weight;
   logic [7:0] current;
   logic [7:0] rate;
   logic       rate_valid;
   logic       rate_ready;
   logic       overrun;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   int m_current;
   int m_rate;
   int m_valid;
   int m_overrun;
   int m_window[$];

   spike_rate_decoder #(.WINDOW(WINDOW)) dut (
      .clk       (clk),
      .rst       (rst),
      .spike     (spike),
      .enable    (enable),
      .weight    (weight),
      .current   (current),
      .rate      (rate),
      .rate_valid(rate_valid),
      .rate_ready(rate_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_current = 0;
      m_rate    = 0;
      m_valid   = 0;
      m_overrun = 0;
      m_window.delete();
   endtask

   task automatic model_edge(input int sp, input int en, input int w, input int rdy);
      int total;
      if (en != 0) begin
         m_current = m_current / 2 + ((sp != 0) ? w : 0);
         if (m_current > 255) m_current = 255;
         m_window.push_back(sp);
         if (m_window.size() == WINDOW) begin
            total = 0;
            foreach (m_window[i]) total += m_window[i];
            if (total > 255) total = 255;
            if (m_valid != 0 && rdy == 0) m_overrun = 1;
            m_rate  = total;
            m_valid = 1;
            m_window.delete();
            return;
         end
      end else begin
         m_window.delete();
      end
      if (m_valid != 0 && rdy != 0) m_valid = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".current"}, int'(current), m_current);
      check({tag, ".rate"}, int'(rate), m_rate);
      check({tag, ".rate_valid"}, int'(rate_valid), m_valid);
      check({tag, ".overrun"}, int'(overrun), m_overrun);
   endtask

   // Called at a falling edge: drive, take one rising edge, check at the next fall.
   task automatic cycle(input string tag, input bit sp, input bit en,
                        input logic [7:0] w, input bit rdy);
      spike      = sp;
      enable     = en;
      weight     = w;
      rate_ready = rdy;
      @(posedge clk);
      model_edge(int'(sp), int'(en), int'(w), int'(rdy));
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      spike = 1'b0;
      enable = 1'b0;
      weight = 8'd0;
      rate_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   initial begin
      int exp_decay[8];
      int pulses;
      logic [7:0] held;

      exp_decay = '{100, 50, 25, 12, 6, 3, 1, 0};
      rst = 1'b0;
      spike = 1'b1;
      enable = 1'b1;
      weight = 8'd200;
      rate_ready = 1'b1;
      model_reset();

      // reset held with active inputs
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_hold", int'({current, rate, rate_valid, overrun}), 0);
      end
      rst = 1'b1;
      for (int i = 0; i < WINDOW; i++) cycle("pre_async", 1'b1, 1'b1, 8'd200, 1'b0);
      check("pre_async.nonzero", int'(current != 0 && rate_valid), 1);
      #2 rst = 1'b0;
      #1;
      check("async.current", int'(current), 0);
      check("async.rate", int'(rate), 0);
      check("async.rate_valid", int'(rate_valid), 0);
      check("async.overrun", int'(overrun), 0);
      @(negedge clk);
      model_reset();
      rst = 1'b1;

      // trace decay
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle("decay", (i == 0), 1'b1, 8'd100, 1'b1);
         check("decay.seq", int'(current), exp_decay[i]);
      end

      // trace saturation
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle("sat", 1'b1, 1'b1, 8'd200, 1'b1);
         check("sat.seq", int'(current), (i == 0) ? 200 : 255);
      end

      // free-running windows, spike on even slots
      do_reset();
      for (int i = 0; i < 3 * WINDOW; i++) begin
         cycle("free", (i % 2 == 0), 1'b1, 8'd10, 1'b1);
         check("free.valid", int'(rate_valid), (i % WINDOW == WINDOW - 1) ? 1 : 0);
         if (i % WINDOW == WINDOW - 1) check("free.rate", int'(rate), 8);
      end
      check("free.overrun", int'(overrun), 0);

      // backpressure: overwrite raises overrun
      do_reset();
      for (int i = 0; i < WINDOW; i++) cycle("bp1", (i < 4), 1'b1, 8'd5, 1'b0);
      check("bp1.rate", int'(rate), 4);
      check("bp1.valid", int'(rate_valid), 1);
      for (int i = 0; i < WINDOW; i++) cycle("bp2", (i < 9), 1'b1, 8'd5, 1'b0);
      check("bp2.rate", int'(rate), 9);
      check("bp2.overrun", int'(overrun), 1);

      // backpressure: accept coincides with completion
      do_reset();
      for (int i = 0; i < WINDOW; i++) cycle("bpa1", (i < 4), 1'b1, 8'd5, 1'b0);
      for (int i = 0; i < WINDOW; i++) cycle("bpa2", (i < 9), 1'b1, 8'd5, (i == WINDOW - 1));
      check("bpa2.rate", int'(rate), 9);
      check("bpa2.valid", int'(rate_valid), 1);
      check("bpa2.overrun", int'(overrun), 0);

      // enable drop discards the partial window
      do_reset();
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cycle("drop_a", (i % 2 == 0), 1'b1, 8'd40, 1'b1);
         pulses += int'(rate_valid);
      end
      held = current;
      for (int i = 0; i < 3; i++) begin
         cycle("drop_off", 1'b1, 1'b0, 8'd90, 1'b1);
         check("drop_off.hold", int'(current), int'(held));
         pulses += int'(rate_valid);
      end
      for (int i = 0; i < WINDOW; i++) begin
         cycle("drop_b", (i == 3 || i == 11), 1'b1, 8'd40, 1'b1);
         pulses += int'(rate_valid);
      end
      check("drop.pulses", pulses, 1);
      check("drop.rate", int'(rate), 2);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 19) != 0,
               8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
